// File: rtl/pc_run_controller_if.sv
// ---------------------------------------------------------------------------
// pc_run_controller_if
//   Instruction-fetch handshake between the PC/run controller and the
//   instruction memory.
//
//   Handshake: the master holds fetch_req high with a stable fetch_addr until
//   the slave answers with fetch_ack. The instruction is taken in the cycle
//   where fetch_req and fetch_ack are both high. fetch_ack may be high in the
//   first request cycle. fetch_ack seen while fetch_req is low is ignored.
//
//   Signals:
//     fetch_req  (master -> slave)  fetch request
//     fetch_addr (master -> slave)  address to fetch, ADDR_W bits
//     fetch_ack  (slave -> master)  instruction valid for fetch_addr
// ---------------------------------------------------------------------------
interface pc_run_controller_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;

    modport master (output fetch_req, output fetch_addr, input fetch_ack);
    modport slave  (input fetch_req, input fetch_addr, output fetch_ack);
endinterface

// File: rtl/pc_run_controller.sv
// ---------------------------------------------------------------------------
// pc_run_controller
//   Owns the program counter and sequences instructions through a
//   HALTED -> FETCH -> EXEC loop. Supports free-run, single-step and
//   address breakpoints. commit is high for exactly the one EXEC cycle of each
//   retired instruction and gates register-file / data-memory writes.
//
//   Optional feature (macro PC_RUN_TRACE_EN): 4-entry history of retired PCs
//   with ports trace_idx, trace_pc and trace_valid_cnt.
//
//   Ports:
//     clk, reset         clock, synchronous active-high reset
//     run_en             level: 1 = free-run, 0 = halt after current instr
//     step_req           pulse: execute one instruction while halted
//     halt_req           pulse: stop after the current instruction
//     fetch_bus          fetch handshake (fetch_req/fetch_addr/fetch_ack)
//     branch_taken/_target, jump/jump_target, jr/jr_target  next-PC sources
//     commit             instruction at pc retires this cycle
//     pc, pc_link        current PC and pc+PC_INC
//     bkpt_addr/bkpt_en  breakpoint slots; bkpt_hit sticky per-slot flags
//     halted             controller is in HALTED
//     retired_count      saturating count of commits
//     state_dbg          current FSM state (0 HALTED, 1 FETCH, 2 EXEC)
// ---------------------------------------------------------------------------
module pc_run_controller #(
    parameter int                ADDR_W   = 32,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                NUM_BKPT = 2,
    parameter int                CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run_en,
    input  logic                         step_req,
    input  logic                         halt_req,
    pc_run_controller_if.master          fetch_bus,
    input  logic                         branch_taken,
    input  logic [ADDR_W-1:0]            branch_target,
    input  logic                         jump,
    input  logic [ADDR_W-1:0]            jump_target,
    input  logic                         jr,
    input  logic [ADDR_W-1:0]            jr_target,
    output logic                         commit,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_link,
    input  logic [NUM_BKPT*ADDR_W-1:0]   bkpt_addr,
    input  logic [NUM_BKPT-1:0]          bkpt_en,
    output logic [NUM_BKPT-1:0]          bkpt_hit,
    output logic                         halted,
    output logic [CNT_W-1:0]             retired_count,
`ifdef PC_RUN_TRACE_EN
    input  logic [1:0]                   trace_idx,
    output logic [ADDR_W-1:0]            trace_pc,
    output logic [2:0]                   trace_valid_cnt,
`endif
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    typedef enum logic {
        M_RUN  = 1'b0,
        M_STEP = 1'b1
    } mode_t;

    localparam logic [ADDR_W-1:0] PC_INC_W = ADDR_W'(PC_INC);

    state_t              state;
    mode_t               mode;
    logic                skip_bkpt;   // suppress breakpoint check on resume
    logic                halt_pend;   // halt_req seen during FETCH/EXEC
    logic                first_fetch; // current cycle is first FETCH cycle
    logic [NUM_BKPT-1:0] bkpt_match;
    logic                bkpt_stop;
    logic [ADDR_W-1:0]   next_pc;

    assign state_dbg = state;
    assign pc_link   = pc + PC_INC_W;

    always_comb begin
        bkpt_match = '0;
        for (int i = 0; i < NUM_BKPT; i++) begin
            bkpt_match[i] = bkpt_en[i] && (bkpt_addr[i*ADDR_W +: ADDR_W] == pc);
        end
    end

    // A breakpoint only fires on the first FETCH cycle of a running
    // instruction that was not just resumed from HALTED.
    assign bkpt_stop = (state == S_FETCH) && first_fetch && (mode == M_RUN)
                       && !skip_bkpt && (|bkpt_match);

    // The request is withdrawn in the cycle a breakpoint fires so the
    // breakpointed instruction is never fetched.
    assign fetch_bus.fetch_req  = (state == S_FETCH) && !bkpt_stop;
    assign fetch_bus.fetch_addr = pc;

    always_comb begin
        if (jr)                next_pc = jr_target;
        else if (jump)         next_pc = jump_target;
        else if (branch_taken) next_pc = branch_target;
        else                   next_pc = pc + PC_INC_W;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_HALTED;
            mode          <= M_RUN;
            pc            <= RESET_PC;
            commit        <= 1'b0;
            halted        <= 1'b1;
            bkpt_hit      <= '0;
            retired_count <= '0;
            skip_bkpt     <= 1'b1;
            halt_pend     <= 1'b0;
            first_fetch   <= 1'b0;
        end else begin
            case (state)
                S_HALTED: begin
                    if (step_req || run_en) begin
                        state       <= S_FETCH;
                        mode        <= step_req ? M_STEP : M_RUN;
                        bkpt_hit    <= '0;
                        skip_bkpt   <= 1'b1;
                        halted      <= 1'b0;
                        first_fetch <= 1'b1;
                    end
                end
                S_FETCH: begin
                    first_fetch <= 1'b0;
                    if (halt_req) halt_pend <= 1'b1;
                    if (bkpt_stop) begin
                        bkpt_hit  <= bkpt_hit | bkpt_match;
                        state     <= S_HALTED;
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
                    end else if (fetch_bus.fetch_ack) begin
                        state  <= S_EXEC;
                        commit <= 1'b1;
                    end
                end
                S_EXEC: begin
                    commit    <= 1'b0;
                    pc        <= next_pc;
                    skip_bkpt <= 1'b0;
                    if (retired_count != {CNT_W{1'b1}}) begin
                        retired_count <= retired_count + CNT_W'(1);
                    end
                    if ((mode == M_STEP) || !run_en || halt_pend || halt_req) begin
                        state     <= S_HALTED;
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
                    end else begin
                        state       <= S_FETCH;
                        first_fetch <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_HALTED;
                    halted <= 1'b1;
                    commit <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_RUN_TRACE_EN
    logic [ADDR_W-1:0] trace_mem [4];
    logic [1:0]        trace_wr_ptr;

    // trace_wr_ptr points at the next slot to write, so the most recent
    // entry sits one below it.
    assign trace_pc = trace_mem[trace_wr_ptr - 2'd1 - trace_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) trace_mem[i] <= RESET_PC;
            trace_wr_ptr    <= '0;
            trace_valid_cnt <= '0;
        end else if (commit) begin
            trace_mem[trace_wr_ptr] <= pc;
            trace_wr_ptr            <= trace_wr_ptr + 2'd1;
            if (trace_valid_cnt != 3'd4) trace_valid_cnt <= trace_valid_cnt + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_run_controller.sv
module tb_pc_run_controller;
    localparam int ADDR_W   = 32;
    localparam int NUM_BKPT = 2;
    localparam int CNT_W    = 32;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       run_en, step_req, halt_req;
    logic                       branch_taken, jump, jr;
    logic [ADDR_W-1:0]          branch_target, jump_target, jr_target;
    logic                       commit, halted;
    logic [ADDR_W-1:0]          pc, pc_link;
    logic [NUM_BKPT*ADDR_W-1:0] bkpt_addr;
    logic [NUM_BKPT-1:0]        bkpt_en, bkpt_hit;
    logic [CNT_W-1:0]           retired_count;
    logic [1:0]                 state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] exp_q[$];

    pc_run_controller_if #(.ADDR_W(ADDR_W)) fbus ();

    pc_run_controller dut (
        .clk           (clk),
        .reset         (reset),
        .run_en        (run_en),
        .step_req      (step_req),
        .halt_req      (halt_req),
        .fetch_bus     (fbus),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .commit        (commit),
        .pc            (pc),
        .pc_link       (pc_link),
        .bkpt_addr     (bkpt_addr),
        .bkpt_en       (bkpt_en),
        .bkpt_hit      (bkpt_hit),
        .halted        (halted),
        .retired_count (retired_count),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run_en = 0; step_req = 0; halt_req = 0; fbus.fetch_ack = 0;
        branch_taken = 0; jump = 0; jr = 0;
        branch_target = '0; jump_target = '0; jr_target = '0;
        bkpt_addr = '0; bkpt_en = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Pulse step_req while halted with fetch_ack tied high; wait (bounded)
    // for the return to HALTED and report the commits seen.
    task automatic step_once(output logic [ADDR_W-1:0] cpc, output int ncommit);
        ncommit = 0;
        cpc     = 'x;
        fbus.fetch_ack = 1;
        step_req = 1;
        tick();
        step_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (commit) begin
                ncommit++;
                cpc = pc;
            end
            if (halted) break;
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_errors++;
            $display("FAIL step_timeout: halted=%b required 1", halted);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h required 0", pc); end
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL reset_halted: got %b required 1", halted); end
        n_checks++; if (commit !== 1'b0) begin n_errors++; $display("FAIL reset_commit: got %b required 0", commit); end
        n_checks++; if (fbus.fetch_req !== 1'b0) begin n_errors++; $display("FAIL reset_fetch_req: got %b required 0", fbus.fetch_req); end
        n_checks++; if (retired_count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d required 0", retired_count); end
        n_checks++; if (bkpt_hit !== '0) begin n_errors++; $display("FAIL reset_bkpt_hit: got %b required 0", bkpt_hit); end
    endtask

    task automatic test_run_sequential();
        logic [ADDR_W-1:0] exp_pc;
        fbus.fetch_ack = 1;
        run_en = 1;
        exp_pc = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (fbus.fetch_req !== 1'b1 || commit !== 1'b0) begin
                n_errors++;
                $display("FAIL run_fetch_phase: fetch_req=%b commit=%b required 1/0", fbus.fetch_req, commit);
            end
            tick();
            n_checks++;
            if (commit !== 1'b1 || pc !== exp_pc) begin
                n_errors++;
                $display("FAIL run_commit: commit=%b pc=%h required 1 pc=%h", commit, pc, exp_pc);
            end
            exp_pc = exp_pc + 2;
        end
        tick();
        n_checks++; if (retired_count !== 32'd4) begin n_errors++; $display("FAIL run_count: got %0d required 4", retired_count); end
        n_checks++; if (pc !== 32'h8) begin n_errors++; $display("FAIL run_pc: got %h required 8", pc); end
        run_en = 0;
        tick();
        tick();
        n_checks++;
        if (halted !== 1'b1 || retired_count !== 32'd5 || pc !== 32'hA) begin
            n_errors++;
            $display("FAIL run_stop: halted=%b count=%0d pc=%h required 1 5 a", halted, retired_count, pc);
        end
    endtask

    task automatic test_step_jump();
        logic [ADDR_W-1:0] cpc;
        int nc;
        for (int k = 0; k < 3; k++) step_once(cpc, nc);
        n_checks++; if (pc !== 32'h10) begin n_errors++; $display("FAIL step_seq_pc: got %h required 10", pc); end
        jump = 1;
        jump_target = 32'h40;
        step_once(cpc, nc);
        jump = 0;
        n_checks++; if (nc !== 1) begin n_errors++; $display("FAIL step_ncommit: got %0d required 1", nc); end
        n_checks++; if (cpc !== 32'h10) begin n_errors++; $display("FAIL step_commit_pc: got %h required 10", cpc); end
        n_checks++; if (pc !== 32'h40) begin n_errors++; $display("FAIL step_jump_pc: got %h required 40", pc); end
        tick();
        n_checks++;
        if (halted !== 1'b1 || commit !== 1'b0) begin
            n_errors++;
            $display("FAIL step_stays_halted: halted=%b commit=%b required 1 0", halted, commit);
        end
    endtask

    task automatic test_breakpoint();
        logic [ADDR_W-1:0] got[$];
        do_reset();
        bkpt_addr = {32'h8, 32'h4};
        bkpt_en   = 2'b10;
        fbus.fetch_ack = 1;
        run_en = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (commit) got.push_back(pc);
            if (halted) break;
        end
        run_en = 0;
        n_checks++;
        if (got.size() != 4 || got[0] !== 32'h0 || got[1] !== 32'h2 || got[2] !== 32'h4 || got[3] !== 32'h6) begin
            n_errors++;
            $display("FAIL bkpt_commits: got %0d commits required 0,2,4,6", got.size());
        end
        n_checks++;
        if (halted !== 1'b1 || pc !== 32'h8 || bkpt_hit !== 2'b10) begin
            n_errors++;
            $display("FAIL bkpt_halt: halted=%b pc=%h hit=%b required 1 8 10", halted, pc, bkpt_hit);
        end
        n_checks++; if (retired_count !== 32'd4) begin n_errors++; $display("FAIL bkpt_count: got %0d required 4", retired_count); end
        step_req = 1;
        tick();
        step_req = 0;
        n_checks++; if (bkpt_hit !== 2'b00) begin n_errors++; $display("FAIL bkpt_clear: got %b required 00", bkpt_hit); end
        tick();
        n_checks++;
        if (commit !== 1'b1 || pc !== 32'h8) begin
            n_errors++;
            $display("FAIL bkpt_resume_commit: commit=%b pc=%h required 1 8", commit, pc);
        end
        tick();
        n_checks++;
        if (halted !== 1'b1 || pc !== 32'hA) begin
            n_errors++;
            $display("FAIL bkpt_resume_pc: halted=%b pc=%h required 1 a", halted, pc);
        end
        bkpt_en = '0;
    endtask

    task automatic test_priority();
        logic [ADDR_W-1:0] cpc;
        logic [ADDR_W-1:0] exp_pc;
        int nc;
        jr_target = 32'h100; jump_target = 32'h200; branch_target = 32'h300;
        for (int k = 0; k < 3; k++) begin
            jr = (k == 0);
            jump = (k <= 1);
            branch_taken = 1;
            exp_pc = (k == 0) ? 32'h100 : (k == 1) ? 32'h200 : 32'h300;
            step_once(cpc, nc);
            n_checks++;
            if (pc !== exp_pc) begin
                n_errors++;
                $display("FAIL priority_%0d: got %h required %h", k, pc, exp_pc);
            end
        end
        jr = 0; jump = 0; branch_taken = 0;
    endtask

    task automatic test_halt_delayed();
        logic [CNT_W-1:0] c0;
        int nc;
        c0 = retired_count;
        nc = 0;
        fbus.fetch_ack = 0;
        run_en = 1;
        tick();
        n_checks++; if (fbus.fetch_req !== 1'b1) begin n_errors++; $display("FAIL delay_req: got %b required 1", fbus.fetch_req); end
        tick();
        halt_req = 1;
        tick();
        halt_req = 0;
        tick();
        n_checks++; if (commit !== 1'b0) begin n_errors++; $display("FAIL delay_no_commit: got %b required 0", commit); end
        fbus.fetch_ack = 1;
        tick();
        if (commit) nc++;
        fbus.fetch_ack = 0;
        tick();
        if (commit) nc++;
        run_en = 0;
        n_checks++;
        if (nc !== 1 || halted !== 1'b1 || retired_count !== c0 + 1) begin
            n_errors++;
            $display("FAIL delay_halt: commits=%0d halted=%b count=%0d required 1 1 %0d", nc, halted, retired_count, c0 + 1);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] cpc;
        int nc;
        jump = 1;
        jump_target = 32'hFFFF_FFFE;
        step_once(cpc, nc);
        jump = 0;
        n_checks++; if (pc_link !== 32'h0) begin n_errors++; $display("FAIL wrap_link: got %h required 0", pc_link); end
        step_once(cpc, nc);
        n_checks++;
        if (cpc !== 32'hFFFF_FFFE || pc !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_pc: committed %h pc %h required fffffffe 0", cpc, pc);
        end
    endtask

    task automatic test_reset_in_exec();
        fbus.fetch_ack = 1;
        run_en = 1;
        tick();
        tick();
        n_checks++; if (commit !== 1'b1) begin n_errors++; $display("FAIL rst_exec_setup: commit=%b required 1", commit); end
        reset = 1;
        tick();
        n_checks++;
        if (commit !== 1'b0 || pc !== 32'h0 || retired_count !== '0 || halted !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_exec: commit=%b pc=%h count=%0d halted=%b required 0 0 0 1", commit, pc, retired_count, halted);
        end
        reset = 0;
        run_en = 0;
    endtask

    // Random traffic against an instruction-level model: each commit must
    // retire the address predicted from the previous commit's redirect inputs.
    task automatic test_random();
        logic [ADDR_W-1:0] exp_pc, nxt;
        logic [CNT_W-1:0]  m_cnt;
        do_reset();
        exp_q.delete();
        exp_q.push_back(32'h0);
        m_cnt = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (pc_link !== pc + 32'd2 || fbus.fetch_addr !== pc) begin
                n_checks++; n_errors++;
                $display("FAIL rand_addr: pc=%h link=%h addr=%h", pc, pc_link, fbus.fetch_addr);
            end
            if (commit) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rand_unexpected_commit: pc=%h required none", pc);
                    exp_pc = pc;
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (pc !== exp_pc || retired_count !== m_cnt || halted !== 1'b0) begin
                        n_errors++;
                        $display("FAIL rand_commit: pc=%h count=%0d halted=%b required %h %0d 0",
                                 pc, retired_count, halted, exp_pc, m_cnt);
                    end
                end
            end
            if (cyc % 16 == 0) run_en = ($urandom_range(0, 3) != 0);
            step_req       = ($urandom_range(0, 9) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            fbus.fetch_ack = ($urandom_range(0, 2) != 0);
            jr             = ($urandom_range(0, 7) == 0);
            jump           = ($urandom_range(0, 5) == 0);
            branch_taken   = ($urandom_range(0, 3) == 0);
            jr_target      = $urandom;
            jump_target    = $urandom;
            branch_target  = $urandom;
            if (commit) begin
                if (jr)                nxt = jr_target;
                else if (jump)         nxt = jump_target;
                else if (branch_taken) nxt = branch_target;
                else                   nxt = exp_pc + 32'd2;
                exp_q.push_back(nxt);
                m_cnt = m_cnt + 1;
            end
        end
        clear_inputs();
        n_checks++;
        if (m_cnt < 50) begin
            n_errors++;
            $display("FAIL rand_progress: commits=%0d required at least 50", m_cnt);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_run_sequential();
        test_step_jump();
        test_breakpoint();
        test_priority();
        test_halt_delayed();
        test_wrap();
        test_reset_in_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
